// File: rtl/wait_cond_monitor.sv
// Multi-channel hardware wait(): each channel blocks on a compare against a shared
// watched value and completes on match, on optional cycle timeout, or is cancelled.
module wait_cond_monitor #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int TIMEOUT_W = 16,
    parameter int SIGNED    = 0,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     value,
    input  logic                 arm_valid,
    output logic                 arm_ready,
    input  logic [CW-1:0]        arm_chan,
    input  logic [2:0]           arm_op,
    input  logic [WIDTH-1:0]     arm_lo,
    input  logic [WIDTH-1:0]     arm_hi,
    input  logic [TIMEOUT_W-1:0] arm_timeout,
    input  logic [CHANNELS-1:0]  cancel,
    output logic [CHANNELS-1:0]  busy,
    output logic [CHANNELS-1:0]  done_ok,
    output logic [CHANNELS-1:0]  done_to,
    output logic                 any_done
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    function automatic logic is_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    logic [CHANNELS-1:0] arm_sel;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] ok_d_vec;
    logic [CHANNELS-1:0] to_d_vec;
    logic                any_done_q;

    // An out-of-range arm_chan selects no channel, so it can never be accepted.
    assign arm_ready = |(arm_sel & ~busy_vec);
    assign busy      = busy_vec;
    assign any_done  = any_done_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        state_t               state_q, state_d;
        logic [2:0]           op_q, op_d;
        logic [WIDTH-1:0]     lo_q, lo_d;
        logic [WIDTH-1:0]     hi_q, hi_d;
        logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
        logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
        logic                 ok_q, ok_d;
        logic                 to_q, to_d;
        logic                 cond;

        assign arm_sel[gi]  = (arm_chan == CW'(gi));
        assign busy_vec[gi] = (state_q == ST_WAIT);
        assign done_ok[gi]  = ok_q;
        assign done_to[gi]  = to_q;
        assign ok_d_vec[gi] = ok_d;
        assign to_d_vec[gi] = to_d;

        always_comb begin
            cond = 1'b0;
            case (op_q)
                3'd0:    cond = (value == lo_q);
                3'd1:    cond = (value != lo_q);
                3'd2:    cond = is_lt(value, lo_q);
                3'd3:    cond = is_lt(lo_q, value);
                3'd4:    cond = !is_lt(lo_q, value);
                3'd5:    cond = !is_lt(value, lo_q);
                3'd6:    cond = is_lt(lo_q, value) && is_lt(value, hi_q);
                default: cond = !is_lt(lo_q, value) || !is_lt(value, hi_q);
            endcase
        end

        always_comb begin
            state_d = state_q;
            op_d    = op_q;
            lo_d    = lo_q;
            hi_d    = hi_q;
            tmo_d   = tmo_q;
            cnt_d   = cnt_q;
            ok_d    = 1'b0;
            to_d    = 1'b0;
            if (state_q == ST_IDLE) begin
                if (arm_valid && arm_sel[gi]) begin
                    state_d = ST_WAIT;
                    op_d    = arm_op;
                    lo_d    = arm_lo;
                    hi_d    = arm_hi;
                    tmo_d   = arm_timeout;
                    cnt_d   = '0;
                end
            end else if (cancel[gi]) begin
                state_d = ST_IDLE;
            end else if (cond) begin
                state_d = ST_IDLE;
                ok_d    = 1'b1;
            end else if (tmo_q != '0 && cnt_q == tmo_q - TIMEOUT_W'(1)) begin
                state_d = ST_IDLE;
                to_d    = 1'b1;
            end else if (cnt_q != '1) begin
                // Saturates so an unbounded wait never wraps into a false expiry.
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                op_q    <= '0;
                lo_q    <= '0;
                hi_q    <= '0;
                tmo_q   <= '0;
                cnt_q   <= '0;
                ok_q    <= 1'b0;
                to_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                op_q    <= op_d;
                lo_q    <= lo_d;
                hi_q    <= hi_d;
                tmo_q   <= tmo_d;
                cnt_q   <= cnt_d;
                ok_q    <= ok_d;
                to_q    <= to_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_done_q <= 1'b0;
        end else begin
            any_done_q <= |(ok_d_vec | to_d_vec);
        end
    end

endmodule

// File: doc/wait_cond_monitor.md
Name: wait_cond_monitor

Overview:
- Synthesizable, multi-channel successor to the `wait(expr)` construct.
- Each of CHANNELS independent channels is armed with a compare op and operand(s) against a shared watched value.
- A channel reports completion when its condition holds, or when its optional cycle timeout expires first.
- Sits beside scheduler/sequencer logic that must block on data-dependent conditions without hand-written compare FSMs.

Parameters:
- WIDTH, 32, width of watched value and operands
- CHANNELS, 4, number of independent wait channels (1..16)
- TIMEOUT_W, 16, width of per-channel timeout counter
- SIGNED, 0, 1 = operands and value compared as two's-complement

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- value  in  WIDTH  watched value, sampled every cycle
- arm_valid  in  1  arm request
- arm_ready  out  1  high when arm_chan is IDLE; request accepted on arm_valid&&arm_ready
- arm_chan  in  max(1,$clog2(CHANNELS))  target channel
- arm_op  in  3  condition opcode (see Behaviour)
- arm_lo  in  WIDTH  operand A / range low bound
- arm_hi  in  WIDTH  range high bound (ignored for ops 0-5)
- arm_timeout  in  TIMEOUT_W  0 = wait forever, else max cycles in WAIT
- cancel  in  CHANNELS  per-channel abort
- busy  out  CHANNELS  channel in WAIT
- done_ok  out  CHANNELS  1-cycle pulse: condition satisfied
- done_to  out  CHANNELS  1-cycle pulse: timeout expired
- any_done  out  1  OR of done_ok|done_to, registered with them

Behaviour:
- Reset (rst=1 at a clock edge):
  - all channels go to IDLE
  - busy, done_ok, done_to, any_done = 0; counters = 0
  - arm_ready reflects IDLE, so it is 1 during/after reset
  - A channel in WAIT when rst asserts is dropped with no done pulse.
- Opcodes, compared against `value`:
  - 0 EQ: value==lo
  - 1 NE: value!=lo
  - 2 LT: value<lo
  - 3 GT: value>lo
  - 4 LE: value<=lo
  - 5 GE: value>=lo
  - 6 IN: lo<value<hi (exclusive)
  - 7 OUT: value<=lo || value>=hi
  - Signedness per SIGNED.
  - If lo>=hi, IN is never true and OUT is always true (no error flag).
- Per-channel FSM:
  - IDLE -> WAIT on accepted arm: latch op/lo/hi/timeout, clear counter. busy=1 from cycle N+1.
  - WAIT: each cycle evaluates the condition on the current `value`, combinationally.
    - If true at cycle k: done_ok=1 at k+1, channel IDLE at k+1, busy=0 at k+1.
    - Else the counter increments. If timeout!=0 and counter reaches timeout-1 while the condition is false, done_to pulses the next cycle and the channel returns to IDLE.
  - Level semantics, as with `wait`: a condition already true in the first WAIT cycle completes there. Minimum arm-to-done_ok latency is 2 cycles.
  - timeout=T (T>0) means at most T evaluation cycles; done_to appears T+1 cycles after acceptance.
  - Condition true in the same cycle as expiry: done_ok wins and done_to stays 0.
  - A transient true value lasting one cycle is caught.
- cancel[i]:
  - In WAIT: channel goes IDLE next cycle, no done pulse.
  - In IDLE: ignored.
  - Cancel in the cycle the condition is true: cancel wins, no pulse.
- Arm while busy: arm_ready=0 for a busy arm_chan; no state change.
- Arm and cancel to the same IDLE channel in the same cycle: the arm is accepted, and cancel has no effect.
- An arm_chan >= CHANNELS gives arm_ready=0, and the request is never accepted.
- Re-arm: a channel may be re-armed in the same cycle its done pulse is high, because it is already IDLE. Only one arm per cycle is possible.
- Channels are fully independent. Multiple done bits may pulse in the same cycle.
- Counter saturates; it never wraps, since it stops at timeout-1.

Test Plan:
- Sequencing, one channel, value driven 0 -> 1 -> 2 at 100-cycle spacing: arm EQ lo=2, timeout=0 -> done_ok exactly 1 cycle after value becomes 2; busy high throughout the wait.
- Arm LT lo=2 while value=2; later set value=0 -> done_ok on the cycle after value=0. Immediately re-arm EQ lo=0 -> done_ok 2 cycles after acceptance (already true).
- Arm IN lo=1 hi=3: values 0, 1, 3 give no pulse; value=2 gives done_ok. Repeat with SIGNED=1, lo=-3, hi=-1, value=-2 -> done_ok; value=5 -> no pulse.
- Arm GT lo=10 timeout=5, value held at 3 -> done_to at acceptance+6, done_ok=0. Second run with value=11 on the 5th evaluation cycle -> done_ok only.
- 4 channels armed (EQ 5, NE 0, GE 7, OUT 2..4), then value=5 -> done_ok on ch0, ch1, ch3 in the same cycle and any_done=1; ch2 stays busy. Then cancel[2] -> busy[2]=0 with no pulse.
- Assert rst mid-wait -> next cycle all outputs 0 and arm_ready=1. Arm to a busy channel -> arm_ready=0, latched operands unchanged.
